// File: rtl/locker_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : locker_arbiter
// Brief    : Round-robin arbiter sharing one locked ctrl_locker channel among
//            N_REQ requesters; tracks the 4-phase token on a synchronised
//            tok_req. Optional hold timeout: LOCKER_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module locker_arbiter #(
    parameter int N_REQ       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TMO_W       = 8,
    parameter int TMO_CYCLES  = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [N_REQ-1:0] done_o,
    output logic             lock_o,
    input  logic             tok_req,
    output logic             busy_o,
    output logic             tmo_o
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16) begin : g_chk_n_req
        $error("locker_arbiter: N_REQ out of range");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_chk_sync
        $error("locker_arbiter: SYNC_STAGES out of range");
    end
    if (TMO_CYCLES < 1 || TMO_CYCLES >= (2 ** TMO_W)) begin : g_chk_tmo
        $error("locker_arbiter: TMO_CYCLES does not fit TMO_W");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                 state_q,  state_d;
    logic [SYNC_STAGES-1:0] sync_q,   sync_d;
    logic [PTR_W-1:0]       ptr_q,    ptr_d;
    logic [PTR_W-1:0]       winner_q, winner_d;
    logic [N_REQ-1:0]       gnt_q,    gnt_d;
    logic [N_REQ-1:0]       done_q,   done_d;
    logic                   lock_q,   lock_d;

    logic                   tok_s;
    logic                   tmo_hit;
    logic                   pick_found;
    logic [PTR_W-1:0]       pick_idx;
    logic [PTR_W-1:0]       ptr_next;
    logic                   go_rel;
    logic                   rel_done;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], tok_req};
    assign tok_s    = sync_q[SYNC_STAGES-1];
    assign ptr_next = (winner_q == PTR_W'(N_REQ - 1)) ? '0 : winner_q + PTR_W'(1);

    // First set request at or above the pointer, wrapping past N_REQ-1.
    always_comb begin
        logic [PTR_W:0] idx_w;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx_w      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_w = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (idx_w >= (PTR_W + 1)'(N_REQ)) begin
                idx_w = idx_w - (PTR_W + 1)'(N_REQ);
            end
            if (!pick_found && req_i[idx_w[PTR_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = idx_w[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        lock_d   = lock_q;
        go_rel   = 1'b0;
        rel_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A token already in the channel means someone else owns it.
                if (!tok_s && pick_found) begin
                    state_d          = S_GRANT;
                    winner_d         = pick_idx;
                    gnt_d            = '0;
                    gnt_d[pick_idx]  = 1'b1;
                    lock_d           = 1'b1;
                end
            end
            S_GRANT: begin
                if (tmo_hit) begin
                    go_rel = 1'b1;
                end else if (tok_s) begin
                    state_d = S_BUSY;
                end else if (!req_i[winner_q]) begin
                    go_rel = 1'b1;
                end
            end
            S_BUSY: begin
                if (tmo_hit) begin
                    go_rel = 1'b1;
                end else if (!tok_s) begin
                    go_rel   = 1'b1;
                    rel_done = 1'b1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_rel) begin
            state_d = S_RELEASE;
            gnt_d   = '0;
            lock_d  = 1'b0;
            ptr_d   = ptr_next;
            if (rel_done) begin
                done_d[winner_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            ptr_q    <= '0;
            winner_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            lock_q   <= lock_d;
        end
    end

`ifdef LOCKER_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    // Counter is zero on GRANT entry and equals cycles spent holding the lock.
    assign tmo_hit = (cnt_q == TMO_W'(TMO_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = 1'b0;
        if (state_q == S_GRANT || state_q == S_BUSY) begin
            cnt_d = cnt_q + TMO_W'(1);
            tmo_d = tmo_hit;
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo_o = tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign tmo_o   = 1'b0;
`endif

    assign gnt_o  = gnt_q;
    assign done_o = done_q;
    assign lock_o = lock_q;
    assign busy_o = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_locker_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_locker_arbiter
// Brief    : Directed vector table plus hand sequences for locker_arbiter
//            (N_REQ=4, SYNC_STAGES=2). Timeout case under LOCKER_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_locker_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       tok;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       lock;
    logic       busy;
    logic       tmo;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_on  = 1'b0;

    locker_arbiter #(
        .N_REQ      (4),
        .SYNC_STAGES(2),
        .TMO_W      (8),
        .TMO_CYCLES (200)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req),
        .gnt_o  (gnt),
        .done_o (done),
        .lock_o (lock),
        .tok_req(tok),
        .busy_o (busy),
        .tmo_o  (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       tok;
        logic [3:0] gnt;
        logic [3:0] done;
        logic       lock;
        logic       busy;
    } vec_t;

    localparam int NV = 27;
    vec_t vt [NV];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic t,
                                input logic [3:0] g, input logic [3:0] d,
                                input logic l, input logic b);
        vec_t v;
        v.rst = r; v.req = q; v.tok = t; v.gnt = g; v.done = d; v.lock = l; v.busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0; req = 4'b0000; tok = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // gnt must be one-hot or zero on every cycle out of reset.
    always @(negedge clk) begin
        if (mon_on && rst) begin
            n_tests++;
            if (!$onehot0(gnt)) begin
                n_fail++;
                $display("FAIL gnt_onehot: got %b expected one-hot or zero", gnt);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int exp_idx;
        rst = 1'b0; req = 4'b0000; tok = 1'b0;

        //          rst  req     tok  gnt     done    lock busy
        vt[0]  = mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        // single request with full token round trip
        vt[1]  = mk(1, 4'b0001, 0, 4'b0001, 4'b0000, 1, 1);
        vt[2]  = mk(1, 4'b0001, 1, 4'b0001, 4'b0000, 1, 1);
        vt[3]  = mk(1, 4'b0001, 1, 4'b0001, 4'b0000, 1, 1);
        vt[4]  = mk(1, 4'b0001, 1, 4'b0001, 4'b0000, 1, 1);
        vt[5]  = mk(1, 4'b0001, 0, 4'b0001, 4'b0000, 1, 1);
        vt[6]  = mk(1, 4'b0001, 0, 4'b0001, 4'b0000, 1, 1);
        vt[7]  = mk(1, 4'b0001, 0, 4'b0000, 4'b0001, 0, 1);
        vt[8]  = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        // pointer now 1: 0011 -> requester 1; abandon it
        vt[9]  = mk(1, 4'b0011, 0, 4'b0010, 4'b0000, 1, 1);
        vt[10] = mk(1, 4'b0001, 0, 4'b0000, 4'b0000, 0, 1);
        vt[11] = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        vt[12] = mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        // abandon of requester 2 moves pointer to 3
        vt[13] = mk(1, 4'b0100, 0, 4'b0100, 4'b0000, 1, 1);
        vt[14] = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1);
        vt[15] = mk(1, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0);
        vt[16] = mk(1, 4'b1111, 0, 4'b1000, 4'b0000, 1, 1);
        vt[17] = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1);
        vt[18] = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        // stray token in IDLE blocks grants until it clears the synchroniser
        vt[19] = mk(1, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0);
        vt[20] = mk(1, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0);
        vt[21] = mk(1, 4'b0001, 1, 4'b0000, 4'b0000, 0, 0);
        vt[22] = mk(1, 4'b0001, 0, 4'b0000, 4'b0000, 0, 0);
        vt[23] = mk(1, 4'b0001, 0, 4'b0000, 4'b0000, 0, 0);
        vt[24] = mk(1, 4'b0001, 0, 4'b0001, 4'b0000, 1, 1);
        vt[25] = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1);
        vt[26] = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);

        @(negedge clk);
        mon_on = 1'b1;
        for (int i = 0; i < NV; i++) begin
            rst = vt[i].rst; req = vt[i].req; tok = vt[i].tok;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d {gnt,done,lock,busy,tmo}", i),
                {21'd0, gnt, done, lock, busy, tmo},
                {21'd0, vt[i].gnt, vt[i].done, vt[i].lock, vt[i].busy, 1'b0});
        end

        // All four requesting: strict rotation 0,1,2,3,0 with 2-cycle gaps
        reset_dut();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_idx = k % 4;
            cyc = 0;
            while (gnt == 4'b0000 && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            if (k > 0) chk($sformatf("rr_gap%0d", k), cyc, 2);
            chk($sformatf("rr_gnt%0d", k), {28'd0, gnt}, 32'd1 << exp_idx);
            tok = 1'b1;
            repeat (3) @(negedge clk);
            tok = 1'b0;
            cyc = 0;
            while (done == 4'b0000 && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("rr_done%0d", k), {28'd0, done}, 32'd1 << exp_idx);
            if (k == 4) req = 4'b0000;
        end
        repeat (2) @(negedge clk);
        chk("rr_idle_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset while BUSY
        reset_dut();
        req = 4'b0001; tok = 1'b1;
        repeat (4) @(negedge clk);
        chk("busy_before_reset", {27'd0, gnt, busy}, {27'd0, 4'b0001, 1'b1});
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs", {22'd0, gnt, done, lock, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1; tok = 1'b0; req = 4'b1111;
        @(negedge clk);
        chk("ptr_after_reset", {28'd0, gnt}, 32'd1);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Sub-cycle token glitches never reach the synchroniser
        reset_dut();
        req = 4'b0010;
        @(negedge clk);
        chk("glitch_grant", {28'd0, gnt}, 32'd2);
        for (int k = 0; k < 4; k++) begin
            #2 tok = 1'b1;
            #2 tok = 1'b0;
            @(negedge clk);
        end
        chk("glitch_hold", {23'd0, gnt, done, busy}, {23'd0, 4'b0010, 4'b0000, 1'b1});
        req = 4'b0000;
        @(negedge clk);
        chk("glitch_abandon", {23'd0, gnt, done, lock}, 32'd0);
        @(negedge clk);

`ifdef LOCKER_ARB_TIMEOUT_EN
        // Token stuck high: forced release 200 cycles after grant
        reset_dut();
        req = 4'b0001; tok = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (!tmo && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_cycle", cyc, 200);
        chk("tmo_release", {23'd0, gnt, done, lock}, 32'd0);
        req = 4'b0000; tok = 1'b0;
        @(negedge clk);
        chk("tmo_pulse_width", {31'd0, tmo}, 32'd0);
        repeat (3) @(negedge clk);
`endif

        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
